jump_input_conditioner: RTL and testbench
=========================================

// Module: jump_input_conditioner
// PURPOSE
//  Conditions the four raw frog-control buttons ahead of the game logic and topAudio.
//  - Synchronises each button, debounces it and converts each press into one jump pulse.
//  - Arbitrates simultaneous presses and enforces a hop cooldown.
//  - Output pulses drive topAudio jumpForward/jumpBackward/jumpRight/jumpLeft and the frog position logic.
// PARAMETERS
//  DEBOUNCE_CYCLES  250_000    consecutive clk cycles a synced input must differ from stable level to flip it (~10 ms @25.1 MHz)
//  COOLDOWN_CYCLES  2_510_000  cycles busy stays high after an accepted jump, pulse cycle included (~100 ms)
//  REPEAT_CYCLES    5_020_000  auto-repeat period while held (AUTO_REPEAT_EN only); must be > COOLDOWN_CYCLES
// PORTS
//  clk              in   1  pixel clock, 25.1 MHz
//  rst_n            in   1  reset: asynchronous assert, active-low
//  btn_forward_in   in   1  raw button, active-high, asynchronous to clk
//  btn_backward_in  in   1  raw button
//  btn_right_in     in   1  raw button
//  btn_left_in      in   1  raw button
//  jump_forward     out  1  1-cycle jump pulse
//  jump_backward    out  1  1-cycle jump pulse
//  jump_right       out  1  1-cycle jump pulse
//  jump_left        out  1  1-cycle jump pulse
//  pressed          out  4  debounced levels {left,right,backward,forward}
//  busy             out  1  high while in COOLDOWN
// BEHAVIOUR
//  - Reset (rst_n=0): all sync flops, stable levels, counters, outputs = 0; FSM = IDLE. Takes effect immediately, regardless of state.
//  - Sync: two flops per button.
//  - Debounce, one counter per button:
//    - Counter increments each cycle sync2 != stable and clears each cycle they are equal.
//    - When the counter reaches DEBOUNCE_CYCLES, stable <= sync2 and the counter clears.
//    - Any glitch back to the stable level restarts the count.
//  - Press event: stable 0->1. Releases generate nothing.
//  - Latency: a clean press held from the first sampling edge E yields its pulse high in the cycle after edge E+DEBOUNCE_CYCLES+3.
//  - FSM IDLE:
//    - On any press event, register exactly one pulse by priority forward > backward > right > left.
//    - Lower-priority simultaneous events are discarded.
//    - Go to COOLDOWN; the cooldown counter loads COOLDOWN_CYCLES-1.
//  - FSM COOLDOWN:
//    - The pulse is high in its first cycle only.
//    - busy=1 for COOLDOWN_CYCLES cycles; counter decrements to 0, then IDLE.
//    - Press events arriving in COOLDOWN are dropped, not queued.
//  - Outputs: jump_* are registered and one-hot or zero, never two high at once.
//  - Button held through reset release: stable starts at 0, so a press event fires after debounce.
//  - Counter widths: $clog2(param+1); no wrap is possible.
// CONFIGURATION
//  Macro AUTO_REPEAT_EN:
//  - Defined:
//    - Track last_dir (the last fired direction) and a repeat counter cleared at each fire.
//    - In IDLE with no new press event: if pressed[last_dir]=1 and the counter has reached REPEAT_CYCLES-1, fire last_dir again and clear the counter.
//    - A new press event always wins over a repeat.
//    - Releasing last_dir clears the repeat counter.
//  - Undefined: only press events produce pulses; the repeat logic is absent.
// TESTING  (DEBOUNCE_CYCLES=4, COOLDOWN_CYCLES=8, REPEAT_CYCLES=20)
//  1. btn_forward_in high at edge 0, held 30 cycles -> single jump_forward in the cycle after edge 7; pressed=4'b0001; busy high 8 cycles.
//  2. btn_right_in toggles every 2 cycles for 12 cycles, then steady high -> no pulse during bounce; jump_right in the cycle after (steady edge + 7).
//  3. btn_right_in and btn_left_in rise at the same edge -> only jump_right; jump_left never asserts.
//  4. Forward press, then backward press debounced while busy=1 -> no jump_backward; re-press after busy falls -> jump_backward.
//  5. rst_n low mid-debounce and during COOLDOWN -> all outputs 0 in the same cycle; after release, a held button re-debounces and fires once.
//  6. AUTO_REPEAT_EN, forward held 60 cycles -> jump_forward pulses 20 cycles apart (edges 8, 28, 48); undefined -> only the edge-8 pulse.

Source files
------------

// File: rtl/jump_input_conditioner_if.sv
// Button-in / jump-out bundle between the raw frog controls and the conditioner.
// master = whoever drives the buttons; slave = the conditioner itself.
interface jump_input_conditioner_if;
    logic       btn_forward_in;
    logic       btn_backward_in;
    logic       btn_right_in;
    logic       btn_left_in;
    logic       jump_forward;
    logic       jump_backward;
    logic       jump_right;
    logic       jump_left;
    logic [3:0] pressed;
    logic       busy;
    logic       fsmState;

    modport master (
        output btn_forward_in, btn_backward_in, btn_right_in, btn_left_in,
        input  jump_forward, jump_backward, jump_right, jump_left,
        input  pressed, busy, fsmState
    );

    modport slave (
        input  btn_forward_in, btn_backward_in, btn_right_in, btn_left_in,
        output jump_forward, jump_backward, jump_right, jump_left,
        output pressed, busy, fsmState
    );
endinterface

// File: rtl/jump_input_conditioner.sv
// Sync + debounce of four frog buttons, priority arbitration and hop cooldown.
// Optional macro AUTO_REPEAT_EN re-fires the last direction while it stays held.
module jump_input_conditioner #(
    parameter int DEBOUNCE_CYCLES = 250_000,
    parameter int COOLDOWN_CYCLES = 2_510_000,
    parameter int REPEAT_CYCLES   = 5_020_000
) (
    input  logic clk,
    input  logic rst_n,
    jump_input_conditioner_if.slave io
);

    localparam int DbW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int CdW = $clog2(COOLDOWN_CYCLES + 1);
    localparam logic [DbW-1:0] DbMax  = DbW'(DEBOUNCE_CYCLES);
    localparam logic [CdW-1:0] CdLoad = CdW'(COOLDOWN_CYCLES - 1);

    typedef enum logic {
        IDLE     = 1'b0,
        COOLDOWN = 1'b1
    } state_t;

    state_t state;
    state_t stateNext;

    // Bit order everywhere: {left, right, backward, forward}; forward is highest priority.
    logic [3:0]     rawBtn;
    logic [3:0]     sync1;
    logic [3:0]     sync2;
    logic [3:0]     stable;
    logic [3:0]     stableD;
    logic [DbW-1:0] dbCnt [4];
    logic [3:0]     pressEvent;
    logic [3:0]     fireVec;
    logic [3:0]     jumpReg;
    logic [CdW-1:0] cdCnt;

    assign rawBtn = {io.btn_left_in, io.btn_right_in, io.btn_backward_in, io.btn_forward_in};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1   <= '0;
            sync2   <= '0;
            stable  <= '0;
            stableD <= '0;
            for (int i = 0; i < 4; i++) begin
                dbCnt[i] <= '0;
            end
        end else begin
            sync1   <= rawBtn;
            sync2   <= sync1;
            stableD <= stable;
            for (int i = 0; i < 4; i++) begin
                if (sync2[i] == stable[i]) begin
                    dbCnt[i] <= '0;
                end else if (dbCnt[i] == DbMax) begin
                    stable[i] <= sync2[i];
                    dbCnt[i]  <= '0;
                end else begin
                    dbCnt[i] <= dbCnt[i] + DbW'(1);
                end
            end
        end
    end

    assign pressEvent = stable & ~stableD;

`ifdef AUTO_REPEAT_EN
    localparam int RpW = $clog2(REPEAT_CYCLES + 1);
    localparam logic [RpW-1:0] RpLast = RpW'(REPEAT_CYCLES - 1);

    logic [RpW-1:0] repCnt;
    logic [1:0]     lastDir;
    logic           lastValid;
    logic [1:0]     fireIdx;

    always_comb begin
        fireIdx = 2'd0;
        case (fireVec)
            4'b0010: fireIdx = 2'd1;
            4'b0100: fireIdx = 2'd2;
            4'b1000: fireIdx = 2'd3;
            default: fireIdx = 2'd0;
        endcase
    end

    // Counter saturates at RpLast; REPEAT_CYCLES > COOLDOWN_CYCLES keeps repeats out of COOLDOWN.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            repCnt    <= '0;
            lastDir   <= 2'd0;
            lastValid <= 1'b0;
        end else if (fireVec != 4'b0000) begin
            repCnt    <= '0;
            lastDir   <= fireIdx;
            lastValid <= 1'b1;
        end else if (!stable[lastDir]) begin
            repCnt <= '0;
        end else if (repCnt != RpLast) begin
            repCnt <= repCnt + RpW'(1);
        end
    end
`endif

    // State register: also owns the cooldown counter and the registered pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cdCnt   <= '0;
            jumpReg <= '0;
        end else begin
            state   <= stateNext;
            jumpReg <= fireVec;
            if (fireVec != 4'b0000) begin
                cdCnt <= CdLoad;
            end else if (state == COOLDOWN && cdCnt != '0) begin
                cdCnt <= cdCnt - CdW'(1);
            end
        end
    end

    always_comb begin
        stateNext = state;
        fireVec   = 4'b0000;
        case (state)
            IDLE: begin
                if (pressEvent != 4'b0000) begin
                    // Isolate the lowest set bit: forward wins, the rest are discarded.
                    fireVec   = pressEvent & (~pressEvent + 4'd1);
                    stateNext = COOLDOWN;
                end
`ifdef AUTO_REPEAT_EN
                else if (lastValid && stable[lastDir] && repCnt == RpLast) begin
                    fireVec   = 4'b0001 << lastDir;
                    stateNext = COOLDOWN;
                end
`endif
            end
            COOLDOWN: begin
                if (cdCnt == '0) begin
                    stateNext = IDLE;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    always_comb begin
        io.jump_forward  = jumpReg[0];
        io.jump_backward = jumpReg[1];
        io.jump_right    = jumpReg[2];
        io.jump_left     = jumpReg[3];
        io.pressed       = stable;
        io.busy          = (state == COOLDOWN);
        io.fsmState      = state;
    end

endmodule

// File: tb/tb_jump_input_conditioner.sv
// Directed bench for jump_input_conditioner with short debounce/cooldown/repeat periods.
// Pulses are logged as {direction, cycle} and compared against hand-computed expectations.
module tb_jump_input_conditioner;

    localparam int DB = 4;
    localparam int CD = 8;
    localparam int RP = 20;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [3:0] btnNow = 4'b0000;
    int cyc = 0;

    int testsRun = 0;
    int testsFailed = 0;
    int multiHot = 0;
    int busyCnt = 0;
    logic [3:0] monDirs;

    logic [31:0] exp_q[$];
    logic [31:0] obs_q[$];

    jump_input_conditioner_if bus();

    assign bus.btn_forward_in  = btnNow[0];
    assign bus.btn_backward_in = btnNow[1];
    assign bus.btn_right_in    = btnNow[2];
    assign bus.btn_left_in     = btnNow[3];

    jump_input_conditioner #(
        .DEBOUNCE_CYCLES(DB),
        .COOLDOWN_CYCLES(CD),
        .REPEAT_CYCLES(RP)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .io(bus)
    );

    // Clock and cycle index (cyc == N at the negedge following posedge N).
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Pulse / busy monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (rst_n) begin
            monDirs = {bus.jump_left, bus.jump_right, bus.jump_backward, bus.jump_forward};
            if (monDirs != 4'b0000) obs_q.push_back({monDirs, 28'(cyc)});
            if ($countones(monDirs) > 1) multiHot++;
            if (bus.busy) busyCnt++;
        end
    end

    task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        testsRun++;
        if (got !== exp) begin
            testsFailed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ev(input logic [3:0] dir, input int c);
        return {dir, 28'(c)};
    endfunction

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic checkIdle(input string tag);
        checkEq({tag, "_jumps"}, {28'd0, bus.jump_left, bus.jump_right, bus.jump_backward, bus.jump_forward}, 32'd0);
        checkEq({tag, "_pressed"}, {28'd0, bus.pressed}, 32'd0);
        checkEq({tag, "_busy"}, {31'd0, bus.busy}, 32'd0);
        checkEq({tag, "_state"}, {31'd0, bus.fsmState}, 32'd0);
    endtask

    task automatic compareLog(input string tag);
        checkEq({tag, "_count"}, obs_q.size(), exp_q.size());
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            checkEq({tag, "_pulse"}, obs_q.pop_front(), exp_q.pop_front());
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0;
        int r;
        int b0;

        // Reset state
        step(3);
        checkIdle("reset");
        rst_n = 1'b1;
        step(2);

        // 1: clean forward press
        n0 = cyc;
        b0 = busyCnt;
        btnNow = 4'b0001;
        exp_q.push_back(ev(4'b0001, n0 + 8));
        step(7);
        checkEq("t1_early_jump", {31'd0, bus.jump_forward}, 32'd0);
        checkEq("t1_early_busy", {31'd0, bus.busy}, 32'd0);
        step(1);
        checkEq("t1_jump", {31'd0, bus.jump_forward}, 32'd1);
        checkEq("t1_busy", {31'd0, bus.busy}, 32'd1);
        checkEq("t1_pressed", {28'd0, bus.pressed}, 32'h1);
        step(7);
        btnNow = 4'b0000;
        step(40);
        checkEq("t1_busy_cycles", busyCnt - b0, CD);
        checkEq("t1_pressed_released", {28'd0, bus.pressed}, 32'h0);
        compareLog("t1");

        // 2: bouncing right button, then steady
        n0 = cyc;
        for (int k = 0; k < 6; k++) begin
            btnNow = (k % 2 == 0) ? 4'b0100 : 4'b0000;
            step(2);
        end
        btnNow = 4'b0100;
        exp_q.push_back(ev(4'b0100, n0 + 20));
        step(14);
        btnNow = 4'b0000;
        step(40);
        compareLog("t2");

        // 3: right and left together, right wins
        n0 = cyc;
        btnNow = 4'b1100;
        exp_q.push_back(ev(4'b0100, n0 + 8));
        step(15);
        btnNow = 4'b0000;
        step(40);
        compareLog("t3");

        // 4: backward debounced during cooldown is dropped, re-press fires
        n0 = cyc;
        b0 = busyCnt;
        btnNow = 4'b0001;
        step(2);
        btnNow = 4'b0011;
        step(10);
        checkEq("t4_pressed_mid", {28'd0, bus.pressed}, 32'h3);
        checkEq("t4_busy_mid", {31'd0, bus.busy}, 32'd1);
        btnNow = 4'b0010;
        step(2);
        btnNow = 4'b0000;
        step(16);
        btnNow = 4'b0010;
        exp_q.push_back(ev(4'b0001, n0 + 8));
        exp_q.push_back(ev(4'b0010, n0 + 38));
        step(15);
        btnNow = 4'b0000;
        step(40);
        checkEq("t4_busy_cycles", busyCnt - b0, 2 * CD);
        compareLog("t4");

        // 5a: reset mid-debounce, held button re-debounces
        n0 = cyc;
        btnNow = 4'b1000;
        step(3);
        #2 rst_n = 1'b0;
        #1 checkIdle("t5a");
        step(2);
        rst_n = 1'b1;
        r = cyc;
        exp_q.push_back(ev(4'b1000, r + 8));
        step(15);
        btnNow = 4'b0000;
        step(40);
        compareLog("t5a");

        // 5b: reset during cooldown
        n0 = cyc;
        btnNow = 4'b0001;
        exp_q.push_back(ev(4'b0001, n0 + 8));
        step(8);
        checkEq("t5b_jump_before", {31'd0, bus.jump_forward}, 32'd1);
        checkEq("t5b_busy_before", {31'd0, bus.busy}, 32'd1);
        #2 rst_n = 1'b0;
        #1 checkIdle("t5b");
        step(2);
        rst_n = 1'b1;
        r = cyc;
        exp_q.push_back(ev(4'b0001, r + 8));
        step(8);
        checkEq("t5b_busy_after", {31'd0, bus.busy}, 32'd1);
        step(7);
        btnNow = 4'b0000;
        step(40);
        compareLog("t5b");

        // 6: long hold (auto-repeat only when enabled)
        n0 = cyc;
        btnNow = 4'b0001;
        exp_q.push_back(ev(4'b0001, n0 + 8));
`ifdef AUTO_REPEAT_EN
        exp_q.push_back(ev(4'b0001, n0 + 8 + RP));
        exp_q.push_back(ev(4'b0001, n0 + 8 + 2 * RP));
`endif
        step(55);
        btnNow = 4'b0000;
        step(40);
        compareLog("t6");

        checkEq("one_hot", multiHot, 32'd0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
